harmonic_lock_tracker: RTL and testbench
========================================

Name: harmonic_lock_tracker

Overview:
- Consumes hsi, delta_hsi and harmonic_locked from the harmonic spacing index stage.
- Turns the raw per-sample lock flag into a debounced, hysteretic lock state.
- Emits acquire, loss and collapse event pulses, plus lock-episode statistics (duration, peak HSI, episode count).
- Feeds the coherence/state-transition logic downstream and runs at the same clk_en sample rate.

Parameters:
- WIDTH, 18, signed data width.
- FRAC, 14, fractional bits (Q14).
- ENTER_TH, 14000, minimum hsi to qualify for acquisition (~0.854).
- EXIT_TH, 12000, hsi below which a held lock starts releasing (~0.73); must be < ENTER_TH.
- ACQ_CNT, 8, consecutive qualifying samples needed to lock (>=1).
- LOSS_CNT, 4, consecutive sub-EXIT_TH samples needed to drop lock (>=1).
- DROP_TH, -2000, signed delta_hsi threshold for abrupt collapse.
- DUR_WIDTH, 16, width of lock_duration.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  sample strobe; state advances only when high
- hsi  in  WIDTH  signed Q14 harmonic spacing index
- delta_hsi  in  WIDTH  signed Q14 deviation from baseline
- harmonic_locked  in  1  raw lock flag
- lock_state  out  2  0 UNLOCKED, 1 ACQUIRING, 2 LOCKED, 3 RELEASING
- locked_stable  out  1  high in LOCKED or RELEASING
- lock_acquired  out  1  one-clk pulse on entry to LOCKED from ACQUIRING
- lock_lost  out  1  one-clk pulse on any exit to UNLOCKED from LOCKED/RELEASING
- collapse_evt  out  1  one-clk pulse on collapse exit
- lock_duration  out  DUR_WIDTH  clk_en samples in current/last lock, saturating
- hsi_peak  out  WIDTH  max hsi in current/last lock
- lock_count  out  8  completed acquisitions, saturating at 255

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low. While rst_n=0 every output and internal register is 0, including the dwell counter; state is UNLOCKED. Reset takes effect immediately, including mid-lock, and emits no pulse.
- Gating: all updates occur on clk edges where clk_en=1. Outputs are registered and reflect the decision one clk after the sampling edge.
- Pulses: lock_acquired, lock_lost and collapse_evt are high for exactly one clk, then clear on the next clk regardless of clk_en.
- Qualifiers (signed compares):
  - good = harmonic_locked && hsi >= ENTER_TH
  - hold = hsi >= EXIT_TH
  - coll = delta_hsi < DROP_TH
- UNLOCKED: good -> ACQUIRING with dwell=1. If ACQ_CNT==1, go directly to LOCKED instead, with entry actions. Otherwise stay.
- ACQUIRING:
  - !good -> UNLOCKED, dwell=0, no pulse.
  - dwell==ACQ_CNT-1 && good -> LOCKED with entry actions: lock_acquired=1, lock_duration=0, hsi_peak=hsi, lock_count+=1 (saturating), dwell=0.
  - Otherwise dwell+=1.
- LOCKED, in priority order:
  - coll -> UNLOCKED, lock_lost=1, collapse_evt=1.
  - !hold -> RELEASING with dwell=1. If LOSS_CNT==1, go directly to UNLOCKED with lock_lost=1.
  - Otherwise stay.
- RELEASING, in priority order:
  - coll -> as in LOCKED.
  - hold -> LOCKED, dwell=0, no pulse.
  - dwell==LOSS_CNT-1 -> UNLOCKED, lock_lost=1.
  - Otherwise dwell+=1.
- Episode statistics: in LOCKED/RELEASING on every sample, including the exit sample, lock_duration saturates at all-ones and hsi_peak = max(hsi_peak, hsi). Both freeze after exit and are overwritten only on the next acquisition.
- harmonic_locked is ignored once LOCKED; hysteresis uses hsi only.

Decomposition:
- Shared package/header harmonic_pkg holds:
  - state encodings LS_UNLOCKED..LS_RELEASING
  - Q14 constants ONE=16384, PHI=26510
  - default ENTER_TH/EXIT_TH/DROP_TH
- One sub-module sat_counter (parameterised width, clear, inc, saturating), instantiated for lock_duration and lock_count.
- The FSM and dwell counter stay in the top.

Test Plan:
- Reset: while in LOCKED with lock_count=3, drive rst_n=0 between clk edges -> all outputs 0 immediately, no pulses.
- Acquisition: hsi=16000, harmonic_locked=1 for 8 samples -> lock_acquired pulse 1 clk after the 8th, lock_state=2, lock_count=1, hsi_peak=16000. Repeat with 7 samples, then hsi=10000 -> back to 0, no pulse.
- Hysteresis:
  - In LOCKED, hsi=13000 for 20 samples -> stays 2.
  - hsi=11000 for 3 samples, then 13000 -> 3 then 2, no lock_lost.
  - hsi=11000 for 4 samples -> lock_lost, state 0, lock_duration frozen.
- Collapse: in LOCKED with hsi=16000, delta_hsi=-3000 -> lock_lost and collapse_evt in the same clk, state 0. delta_hsi=-1999 -> no collapse.
- Gating and saturation: clk_en=0 for 50 clks with qualifying inputs -> state unchanged. With DUR_WIDTH=4, hold LOCKED 30 samples -> lock_duration=15.
- Peak tracking: in LOCKED, hsi sequence 15000, 16200, 15500 -> hsi_peak=16200, and it persists after lock_lost.

Source files
------------

// File: rtl/harmonic_pkg.sv
// Shared definitions for the harmonic lock tracker.
// Holds the lock-state encodings, the Q14 reference constants, the default
// qualification thresholds, and a small elaboration-time helper.
package harmonic_pkg;

    typedef enum logic [1:0] {
        LS_UNLOCKED  = 2'd0,
        LS_ACQUIRING = 2'd1,
        LS_LOCKED    = 2'd2,
        LS_RELEASING = 2'd3
    } lock_state_e;

    // Q14 reference constants
    localparam int ONE = 16384;
    localparam int PHI = 26510;

    // Default thresholds (Q14)
    localparam int DEF_ENTER_TH = 14000;
    localparam int DEF_EXIT_TH  = 12000;
    localparam int DEF_DROP_TH  = -2000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/harmonic_lock_tracker_sat_counter.sv
// sat_counter: unsigned counter that sticks at all-ones.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   i_clr       synchronous clear (wins over i_inc)
//   i_inc       increment by one unless already saturated
//   o_q         current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/harmonic_lock_tracker.sv
// harmonic_lock_tracker: debounced, hysteretic lock tracker for the harmonic
// spacing index. Converts the raw per-sample lock flag into a four-state lock
// FSM, emits acquire/loss/collapse pulses and keeps per-episode statistics.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   clk_en             sample strobe; state advances only when high
//   hsi, delta_hsi     signed Q14 index and its deviation from baseline
//   harmonic_locked    raw lock flag (used only while acquiring)
//   lock_state         0 UNLOCKED, 1 ACQUIRING, 2 LOCKED, 3 RELEASING
//   locked_stable      high in LOCKED or RELEASING
//   lock_acquired      one-clk pulse on ACQUIRING/UNLOCKED -> LOCKED
//   lock_lost          one-clk pulse on LOCKED/RELEASING -> UNLOCKED
//   collapse_evt       one-clk pulse when the exit was caused by a collapse
//   lock_duration      samples in the current/last lock, saturating
//   hsi_peak           max hsi seen in the current/last lock
//   lock_count         completed acquisitions, saturating at 255
module harmonic_lock_tracker
    import harmonic_pkg::*;
#(
    parameter int WIDTH     = 18,
    parameter int FRAC      = 14,
    parameter int ENTER_TH  = DEF_ENTER_TH,
    parameter int EXIT_TH   = DEF_EXIT_TH,
    parameter int ACQ_CNT   = 8,
    parameter int LOSS_CNT  = 4,
    parameter int DROP_TH   = DEF_DROP_TH,
    parameter int DUR_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clk_en,
    input  logic signed [WIDTH-1:0]     hsi,
    input  logic signed [WIDTH-1:0]     delta_hsi,
    input  logic                        harmonic_locked,
    output logic [1:0]                  lock_state,
    output logic                        locked_stable,
    output logic                        lock_acquired,
    output logic                        lock_lost,
    output logic                        collapse_evt,
    output logic [DUR_WIDTH-1:0]        lock_duration,
    output logic signed [WIDTH-1:0]     hsi_peak,
    output logic [7:0]                  lock_count
);

    localparam int DWELL_W = $clog2(max_int(ACQ_CNT, LOSS_CNT) + 1);

    localparam logic signed [WIDTH-1:0] C_ENTER = ENTER_TH[WIDTH-1:0];
    localparam logic signed [WIDTH-1:0] C_EXIT  = EXIT_TH[WIDTH-1:0];
    localparam logic signed [WIDTH-1:0] C_DROP  = DROP_TH[WIDTH-1:0];

    localparam logic [DWELL_W-1:0] C_ACQ_LAST  = DWELL_W'(ACQ_CNT - 1);
    localparam logic [DWELL_W-1:0] C_LOSS_LAST = DWELL_W'(LOSS_CNT - 1);

    lock_state_e        r_state;
    lock_state_e        w_state_nxt;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] w_dwell_nxt;

    logic               r_acq;
    logic               r_lost;
    logic               r_coll;
    logic signed [WIDTH-1:0] r_peak;

    logic w_good;
    logic w_hold;
    logic w_coll;
    logic w_in_lock;
    logic w_enter;
    logic w_exit;
    logic w_coll_exit;

    // Sample qualifiers, all signed compares
    assign w_good = harmonic_locked && (hsi >= C_ENTER);
    assign w_hold = (hsi >= C_EXIT);
    assign w_coll = (delta_hsi < C_DROP);

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LS_UNLOCKED;
            r_dwell <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dwell <= w_dwell_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_dwell_nxt = r_dwell;
        if (clk_en) begin
            unique case (r_state)
                LS_UNLOCKED: begin
                    if (w_good) begin
                        if (ACQ_CNT == 1) begin
                            w_state_nxt = LS_LOCKED;
                            w_dwell_nxt = '0;
                        end else begin
                            w_state_nxt = LS_ACQUIRING;
                            w_dwell_nxt = DWELL_W'(1);
                        end
                    end
                end
                LS_ACQUIRING: begin
                    if (!w_good) begin
                        w_state_nxt = LS_UNLOCKED;
                        w_dwell_nxt = '0;
                    end else if (r_dwell == C_ACQ_LAST) begin
                        w_state_nxt = LS_LOCKED;
                        w_dwell_nxt = '0;
                    end else begin
                        w_dwell_nxt = r_dwell + 1'b1;
                    end
                end
                LS_LOCKED: begin
                    if (w_coll) begin
                        w_state_nxt = LS_UNLOCKED;
                        w_dwell_nxt = '0;
                    end else if (!w_hold) begin
                        if (LOSS_CNT == 1) begin
                            w_state_nxt = LS_UNLOCKED;
                            w_dwell_nxt = '0;
                        end else begin
                            w_state_nxt = LS_RELEASING;
                            w_dwell_nxt = DWELL_W'(1);
                        end
                    end
                end
                LS_RELEASING: begin
                    if (w_coll) begin
                        w_state_nxt = LS_UNLOCKED;
                        w_dwell_nxt = '0;
                    end else if (w_hold) begin
                        w_state_nxt = LS_LOCKED;
                        w_dwell_nxt = '0;
                    end else if (r_dwell == C_LOSS_LAST) begin
                        w_state_nxt = LS_UNLOCKED;
                        w_dwell_nxt = '0;
                    end else begin
                        w_dwell_nxt = r_dwell + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = LS_UNLOCKED;
                    w_dwell_nxt = '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Output / action decode. Transitions are read off the current and
    // next state so the event strobes can never disagree with the FSM.
    // ---------------------------------------------------------------
    always_comb begin
        w_in_lock   = 1'b0;
        w_enter     = 1'b0;
        w_exit      = 1'b0;
        w_coll_exit = 1'b0;
        if (clk_en) begin
            w_in_lock = (r_state == LS_LOCKED) || (r_state == LS_RELEASING);
            w_enter   = !w_in_lock && (w_state_nxt == LS_LOCKED);
            w_exit    = w_in_lock && (w_state_nxt == LS_UNLOCKED);
            // Collapse has top priority in both lock states, so a lock
            // exit with coll asserted is always a collapse exit.
            w_coll_exit = w_exit && w_coll;
        end
    end

    // Pulses are refreshed every clk so they drop after one cycle even
    // when the next edge has clk_en low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acq  <= 1'b0;
            r_lost <= 1'b0;
            r_coll <= 1'b0;
        end else begin
            r_acq  <= w_enter;
            r_lost <= w_exit;
            r_coll <= w_coll_exit;
        end
    end

    // Peak restarts at the entry sample and tracks through the exit sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak <= '0;
        end else if (w_enter) begin
            r_peak <= hsi;
        end else if (w_in_lock && (hsi > r_peak)) begin
            r_peak <= hsi;
        end
    end

    sat_counter #(.W(DUR_WIDTH)) u_dur (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_enter),
        .i_inc (w_in_lock),
        .o_q   (lock_duration)
    );

    sat_counter #(.W(8)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (1'b0),
        .i_inc (w_enter),
        .o_q   (lock_count)
    );

    assign lock_state    = r_state;
    assign locked_stable = (r_state == LS_LOCKED) || (r_state == LS_RELEASING);
    assign lock_acquired = r_acq;
    assign lock_lost     = r_lost;
    assign collapse_evt  = r_coll;
    assign hsi_peak      = r_peak;

endmodule

// File: tb/tb_harmonic_lock_tracker.sv
module tb_harmonic_lock_tracker;

    localparam int W      = 18;
    localparam int DW     = 4;
    localparam int ENTER  = 14000;
    localparam int EXITT  = 12000;
    localparam int DROP   = -2000;
    localparam int ACQ    = 8;
    localparam int LOSS   = 4;
    localparam int DURMAX = (1 << DW) - 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                clk_en = 1'b0;
    logic signed [W-1:0] hsi = '0;
    logic signed [W-1:0] delta_hsi = '0;
    logic                harmonic_locked = 1'b0;
    logic [1:0]          lock_state;
    logic                locked_stable, lock_acquired, lock_lost, collapse_evt;
    logic [DW-1:0]       lock_duration;
    logic signed [W-1:0] hsi_peak;
    logic [7:0]          lock_count;

    harmonic_lock_tracker #(.DUR_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .hsi(hsi),
        .delta_hsi(delta_hsi), .harmonic_locked(harmonic_locked),
        .lock_state(lock_state), .locked_stable(locked_stable),
        .lock_acquired(lock_acquired), .lock_lost(lock_lost),
        .collapse_evt(collapse_evt), .lock_duration(lock_duration),
        .hsi_peak(hsi_peak), .lock_count(lock_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (episode-level view) ----------------
    typedef struct {
        int st; int stable; int acq; int lost; int col;
        int dur; int peak; int cnt;
    } exp_t;

    exp_t q[$];

    bit m_locked;
    int m_good_run, m_low_run, m_dur, m_peak, m_cnt;

    task automatic model_reset();
        m_locked = 0; m_good_run = 0; m_low_run = 0;
        m_dur = 0; m_peak = 0; m_cnt = 0;
    endtask

    // One clock: inputs presented at negedge, expectation for the following edge queued
    task automatic step(input bit en, input int h, input int d, input bit lk);
        exp_t e;
        bit good, hold, coll;
        @(negedge clk);
        clk_en = en; hsi = h[W-1:0]; delta_hsi = d[W-1:0]; harmonic_locked = lk;
        good = lk && (h >= ENTER);
        hold = (h >= EXITT);
        coll = (d < DROP);
        e.acq = 0; e.lost = 0; e.col = 0;
        if (en) begin
            if (!m_locked) begin
                if (good) begin
                    m_good_run++;
                    if (m_good_run >= ACQ) begin
                        m_locked = 1; m_good_run = 0; m_low_run = 0;
                        e.acq = 1; m_dur = 0; m_peak = h;
                        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                    end
                end else begin
                    m_good_run = 0;
                end
            end else begin
                m_dur = (m_dur < DURMAX) ? m_dur + 1 : DURMAX;
                if (h > m_peak) m_peak = h;
                if (coll) begin
                    m_locked = 0; m_low_run = 0; e.lost = 1; e.col = 1;
                end else if (!hold) begin
                    m_low_run++;
                    if (m_low_run >= LOSS) begin
                        m_locked = 0; m_low_run = 0; e.lost = 1;
                    end
                end else begin
                    m_low_run = 0;
                end
            end
        end
        e.st     = m_locked ? ((m_low_run > 0) ? 3 : 2) : ((m_good_run > 0) ? 1 : 0);
        e.stable = m_locked;
        e.dur    = m_dur;
        e.peak   = m_peak;
        e.cnt    = m_cnt;
        q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            chk("lock_state",    int'(lock_state),      e.st);
            chk("locked_stable", int'(locked_stable),   e.stable);
            chk("lock_acquired", int'(lock_acquired),   e.acq);
            chk("lock_lost",     int'(lock_lost),       e.lost);
            chk("collapse_evt",  int'(collapse_evt),    e.col);
            chk("lock_duration", int'(lock_duration),   e.dur);
            chk("hsi_peak",      int'(hsi_peak),        e.peak);
            chk("lock_count",    int'(lock_count),      e.cnt);
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, " lock_state"},    int'(lock_state),    0);
        chk({tag, " locked_stable"}, int'(locked_stable), 0);
        chk({tag, " lock_acquired"}, int'(lock_acquired), 0);
        chk({tag, " lock_lost"},     int'(lock_lost),     0);
        chk({tag, " collapse_evt"},  int'(collapse_evt),  0);
        chk({tag, " lock_duration"}, int'(lock_duration), 0);
        chk({tag, " hsi_peak"},      int'(hsi_peak),      0);
        chk({tag, " lock_count"},    int'(lock_count),    0);
    endtask

    task automatic acquire(input int h);
        repeat (ACQ) step(1, h, 0, 1);
    endtask

    task automatic collapse();
        step(1, 16000, -3000, 0);
    endtask

    int h, d, band;
    bit en, lk;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // Acquisition from 8 qualifying samples, then release
        acquire(16000);
        step(1, 16000, 0, 0);
        repeat (4) step(1, 11000, 0, 0);
        // 7 qualifying samples then a disqualifying one: no lock
        repeat (7) step(1, 16000, 0, 1);
        step(1, 10000, 0, 1);
        step(1, 10000, 0, 1);

        // Hysteresis
        acquire(16000);
        repeat (20) step(1, 13000, 0, 0);
        repeat (3) step(1, 11000, 0, 0);
        step(1, 13000, 0, 0);
        repeat (4) step(1, 11000, 0, 0);
        repeat (3) step(1, 5000, 0, 0);

        // Collapse and the non-collapse boundary
        acquire(16000);
        collapse();
        acquire(16000);
        repeat (3) step(1, 16000, -1999, 0);
        step(1, 16000, -2000, 0);

        // Gating: no advance while clk_en low, even with collapse-level inputs
        repeat (50) step(0, 16000, -3000, 1);
        // Duration saturation
        repeat (30) step(1, 15000, 0, 0);
        collapse();

        // Peak tracking persists after lock loss
        acquire(15000);
        step(1, 16200, 0, 0);
        step(1, 15500, 0, 0);
        repeat (4) step(1, 11000, 0, 0);
        repeat (5) step(1, 9000, 0, 1);

        // Randomized traffic including the threshold edges
        repeat (800) begin
            en   = ($urandom_range(0, 9) < 8);
            lk   = ($urandom_range(0, 9) < 8);
            band = $urandom_range(0, 9);
            case (band)
                0, 1, 2, 3: h = $urandom_range(14000, 17000);
                4, 5:       h = $urandom_range(12000, 13999);
                6:          h = $urandom_range(9000, 11999);
                7:          h = int'($urandom_range(0, 40000)) - 20000;
                8:          h = (($urandom_range(0, 1) == 1) ? 14000 : 13999);
                default:    h = (($urandom_range(0, 1) == 1) ? 12000 : 11999);
            endcase
            band = $urandom_range(0, 19);
            if (band == 0)      d = -2001 - int'($urandom_range(0, 3000));
            else if (band == 1) d = -2000;
            else                d = int'($urandom_range(0, 4000)) - 1999;
            step(en, h, d, lk);
        end

        // Reset mid-lock with lock_count = 3
        step(0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b0;
        model_reset();
        q.delete();
        @(negedge clk) rst_n = 1'b1;
        acquire(16000);
        collapse();
        acquire(16000);
        collapse();
        acquire(16000);
        step(1, 16500, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("midlock_reset");
        model_reset();
        q.delete();
        @(posedge clk);
        #1 chk_zero("reset_held");
        @(negedge clk) rst_n = 1'b1;
        step(1, 16000, 0, 1);
        step(1, 16000, 0, 1);

        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
